// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-locked round-robin arbiter feeding one stream through a 2-entry skid stage
module stream_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SOURCES = 4,
  localparam int SRC_W = $clog2(NUM_SOURCES)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SOURCES-1:0]            in_last,
  input  logic [NUM_SOURCES-1:0]            in_valid,
  output logic [NUM_SOURCES-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic [SRC_W-1:0]                  out_src,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy
);
  typedef enum logic {IDLE, LOCKED} arb_t;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} stg_t;
  typedef logic [SRC_W:0] ext_t;
  arb_t arb_q, arb_d;
  stg_t stg_q, stg_d;
  logic [SRC_W-1:0] rr_q, rr_d, gnt_q, gnt_d, os_q, os_d, bs_q, bs_d, win, idx;
  logic [DATA_WIDTH-1:0] od_q, od_d, bd_q, bd_d, sel_data;
  logic ol_q, ol_d, bl_q, bl_d, can_take, in_fire, out_fire, end_pkt, load_out, load_buf, flush;
  ext_t sum;
  // scan downward so the source closest to rr_q (smallest offset) wins
  always_comb begin
    win = rr_q;
    sum = '0;
    idx = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + ext_t'(k);
      idx = SRC_W'(sum >= ext_t'(NUM_SOURCES) ? sum - ext_t'(NUM_SOURCES) : sum);
      if (in_valid[idx]) win = idx;
    end
  end
  always_comb begin
    sel_data = '0;
    in_ready = '0;
    can_take = arb_q == LOCKED && stg_q != FULL;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (gnt_q == SRC_W'(i)) sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      in_ready[i] = can_take && gnt_q == SRC_W'(i);
    end
  end
  always_comb begin
    in_fire = can_take && in_valid[gnt_q];
    out_fire = stg_q != EMPTY && out_ready;
    end_pkt = in_fire && in_last[gnt_q];
    arb_d = arb_q == IDLE ? (|in_valid ? LOCKED : IDLE) : (end_pkt ? IDLE : LOCKED);
    gnt_d = arb_q == IDLE && |in_valid ? win : gnt_q;
    rr_d = end_pkt ? (gnt_q == SRC_W'(NUM_SOURCES - 1) ? '0 : gnt_q + SRC_W'(1)) : rr_q;
    load_out = in_fire && (stg_q == EMPTY || out_fire);
    load_buf = in_fire && stg_q == BUSY && !out_fire;
    flush = stg_q == FULL && out_fire;
    od_d = load_out ? sel_data : flush ? bd_q : od_q;
    ol_d = load_out ? in_last[gnt_q] : flush ? bl_q : ol_q;
    os_d = load_out ? gnt_q : flush ? bs_q : os_q;
    bd_d = load_buf ? sel_data : bd_q;
    bl_d = load_buf ? in_last[gnt_q] : bl_q;
    bs_d = load_buf ? gnt_q : bs_q;
    stg_d = in_fire && !out_fire ? (stg_q == EMPTY ? BUSY : FULL) :
            !in_fire && out_fire ? (stg_q == FULL ? BUSY : EMPTY) : stg_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_q <= IDLE;
      stg_q <= EMPTY;
      rr_q <= '0;
      gnt_q <= '0;
      od_q <= '0;
      ol_q <= 1'b0;
      os_q <= '0;
      bd_q <= '0;
      bl_q <= 1'b0;
      bs_q <= '0;
    end else begin
      arb_q <= arb_d;
      stg_q <= stg_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      od_q <= od_d;
      ol_q <= ol_d;
      os_q <= os_d;
      bd_q <= bd_d;
      bl_q <= bl_d;
      bs_q <= bs_d;
    end
  end
  assign out_data = od_q;
  assign out_last = ol_q;
  assign out_src = os_q;
  assign out_valid = stg_q != EMPTY;
  assign busy = arb_q == LOCKED;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: randomized and directed scoreboard bench for stream_rr_arbiter
module tb_stream_rr_arbiter;
  localparam int DW = 32, N = 4, SW = 2;
  logic clk = 1'b0, reset_n;
  logic [N*DW-1:0] in_data;
  logic [N-1:0] in_last, in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic out_last, out_valid, out_ready, busy;
  logic [SW-1:0] out_src;
  stream_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SOURCES(N)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy));
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0, acc = 0, emitted = 0, occ = 0;
  int vprob = 100, rprob = 100, m_grant = 0, m_ptr = 0;
  bit run = 1'b0, m_locked = 1'b0;
  logic [32:0] pend[N][$];
  logic [N-1:0] cur_v = '0;
  logic [34:0] exp_q[$];
  int out_log[$], out_t[$];
  logic [DW-1:0] out_dlog[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic int winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  task automatic wait_emit(input int target, input int budget, input string name);
    int n = 0;
    while (emitted < target && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    chk(name, emitted >= target, 1);
  endtask
  task automatic clear_logs();
    out_log.delete(); out_t.delete(); out_dlog.delete();
  endtask
  // stimulus and packet-level arbitration model
  initial forever begin
    @(negedge clk);
    if (!run) begin
      cur_v = '0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
      continue;
    end
    for (int s = 0; s < N; s++) begin
      if (!cur_v[s] && pend[s].size() > 0 && int'($urandom_range(99)) < vprob) cur_v[s] = 1'b1;
      in_valid[s] = cur_v[s];
      in_last[s] = cur_v[s] ? pend[s][0][32] : 1'($urandom);
      in_data[s*DW +: DW] = cur_v[s] ? pend[s][0][31:0] : $urandom;
    end
    out_ready = int'($urandom_range(99)) < rprob;
    #1;
    chk("in_ready_onehot", 64'($countones(in_ready) <= 1), 1);
    chk("busy", busy, m_locked);
    if (!m_locked) begin
      chk("bubble_in_ready", in_ready, 0);
      if (in_valid != '0) begin
        m_grant = winner(in_valid, m_ptr);
        m_locked = 1'b1;
      end
    end else chk("grant_mask", in_ready & ~(N'(1) << m_grant), 0);
    for (int s = 0; s < N; s++) if (in_valid[s] && in_ready[s]) begin
      exp_q.push_back({2'(s), pend[s][0]});
      acc++;
      if (pend[s][0][32]) begin
        m_locked = 1'b0;
        m_ptr = (s + 1) % N;
      end
      void'(pend[s].pop_front());
      cur_v[s] = 1'b0;
    end
  end
  // output monitor
  initial forever begin
    @(negedge clk); #2;
    if (!run) begin
      occ = 0;
      continue;
    end
    chk("out_valid", out_valid, occ > 0);
    if (out_valid && out_ready) begin
      chk("beat_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("beat", {out_src, out_last, out_data}, exp_q.pop_front());
      out_log.push_back(int'(out_src));
      out_t.push_back(cyc);
      out_dlog.push_back(out_data);
      emitted++;
    end
    occ = acc - emitted;
    chk("occupancy", occ >= 0 && occ <= 2, 1);
  end
  initial begin
    int a0, e0, total;
    int e_src[5] = '{1, 1, 1, 2, 0};
    logic [DW-1:0] e_dat[5] = '{32'hA1, 32'hA2, 32'hA3, 32'hC0, 32'hB1};
    reset_n = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int p = 0; p < 3; p++) for (int s = 0; s < N; s++) pend[s].push_back({1'b1, 32'(s * 16 + p)});
    run = 1'b1;
    wait_emit(12, 200, "rr_done");
    if (out_log.size() >= 12) begin
      for (int i = 0; i < 12; i++) chk("rr_src", out_log[i], i % 4);
      for (int i = 1; i < 12; i++) chk("rr_spacing", out_t[i] - out_t[i-1], 2);
    end
    pend[0].push_back({1'b1, 32'hB0});
    wait_emit(13, 50, "lock_prep");
    clear_logs();
    pend[1].push_back({1'b0, 32'hA1}); pend[1].push_back({1'b0, 32'hA2}); pend[1].push_back({1'b1, 32'hA3});
    pend[0].push_back({1'b1, 32'hB1});
    pend[2].push_back({1'b1, 32'hC0});
    wait_emit(18, 100, "lock_done");
    if (out_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("lock_src", out_log[i], e_src[i]);
        chk("lock_data", out_dlog[i], e_dat[i]);
      end
      chk("lock_contig1", out_t[1] - out_t[0], 1);
      chk("lock_contig2", out_t[2] - out_t[1], 1);
    end
    clear_logs();
    rprob = 0;
    a0 = acc; e0 = emitted;
    for (int b = 0; b < 4; b++) pend[1].push_back({b == 3, 32'hD1 + 32'(b)});
    repeat (5) @(negedge clk);
    #3;
    chk("bp_accepted", acc - a0, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    rprob = 100;
    wait_emit(e0 + 4, 50, "bp_done");
    if (out_dlog.size() >= 4) for (int i = 0; i < 4; i++) chk("bp_data", out_dlog[i], 32'hD1 + 32'(i));
    pend[2].push_back({1'b1, 32'hE2});
    wait_emit(emitted + 1, 50, "wrap_prep");
    clear_logs();
    e0 = emitted;
    pend[3].push_back({1'b1, 32'hF3});
    pend[0].push_back({1'b1, 32'hF0});
    wait_emit(e0 + 2, 50, "wrap_done");
    if (out_log.size() >= 2) begin
      chk("wrap_first", out_log[0], 3);
      chk("wrap_second", out_log[1], 0);
    end
    vprob = 60; rprob = 70; total = 0;
    for (int s = 0; s < N; s++) for (int p = 0; p < 12; p++) begin
      int len = int'($urandom_range(1, 4));
      for (int b = 0; b < len; b++) pend[s].push_back({b == len - 1, 8'(s), 8'(p), 16'(b)});
      total += len;
    end
    wait_emit(emitted + total, 4000, "soak_done");
    chk("soak_drained", exp_q.size(), 0);
    vprob = 100; rprob = 0;
    for (int b = 0; b < 4; b++) pend[0].push_back({b == 3, 32'h50 + 32'(b)});
    a0 = 0;
    while (!out_valid && a0 < 20) begin
      @(negedge clk); #3;
      a0++;
    end
    chk("rst_pre_valid", out_valid, 1);
    @(posedge clk); #2;
    run = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    for (int s = 0; s < N; s++) pend[s].delete();
    exp_q.delete(); clear_logs();
    acc = 0; emitted = 0; m_locked = 1'b0; m_ptr = 0; rprob = 100;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < N; s++) pend[s].push_back({1'b1, 32'h70 + 32'(s)});
    run = 1'b1;
    wait_emit(4, 50, "post_rst_done");
    if (out_log.size() >= 1) chk("post_rst_first", out_log[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
